// File: rtl/sobel_frame_writer_if.sv
// Pixel-stream, capture-control and read-port signals of the Sobel frame writer.
interface sobel_frame_writer_if;
  logic [9:0]  hcntr;
  logic [9:0]  vcntr;
  logic [7:0]  pix_in;
  logic        capture_req;
  logic        busy;
  logic        done;
  logic [13:0] wr_count;
  logic [13:0] rd_addr;
  logic [7:0]  rd_data;

  modport master (
    output hcntr, vcntr, pix_in, capture_req, rd_addr,
    input  busy, done, wr_count, rd_data
  );

  modport slave (
    input  hcntr, vcntr, pix_in, capture_req, rd_addr,
    output busy, done, wr_count, rd_data
  );
endinterface

// File: rtl/sobel_frame_writer.sv
// Decimates the 4x4-replicated Sobel output stream back to one sample per
// image pixel and captures one WIDTH x HEIGHT frame per request into a block
// RAM, with a registered read-first random-access read port.
module sobel_frame_writer #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 96,
  parameter int H_OFF  = 64,
  parameter int V_OFF  = 48,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  sobel_frame_writer_if.slave bus
);

  localparam int          DEPTH     = WIDTH * HEIGHT;
  localparam logic [9:0]  H_LO      = 10'(H_OFF);
  localparam logic [9:0]  H_HI      = 10'(H_OFF + 4 * WIDTH - 1);
  localparam logic [9:0]  V_LO      = 10'(V_OFF);
  localparam logic [9:0]  V_HI      = 10'(V_OFF + 4 * HEIGHT - 1);
  localparam logic [13:0] LAST_ADDR = 14'(DEPTH - 1);
  localparam logic [14:0] DEPTH_W   = 15'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [13:0]           wr_count_q, wr_count_d;
  logic [7:0]            rd_data_q, rd_data_d;
  // Counter delay line: LAT entries of {vcntr, hcntr}, newest in the low bits.
  logic [LAT*20-1:0]     pipe_q, pipe_d;
  logic [7:0]            mem [DEPTH];

  logic [9:0]            hd, vd, h_rel, v_rel;
  logic                  samp, fs, wr_en;
  logic [13:0]           wr_addr;

  // Shift the counters in; the cast drops the oldest entry off the top.
  always_comb begin
    pipe_d = (LAT*20)'({pipe_q, bus.vcntr, bus.hcntr});
  end

  // Decode the delayed counters into sample strobe, frame start and address.
  always_comb begin
    vd      = pipe_q[LAT*20-1 -: 10];
    hd      = pipe_q[LAT*20-11 -: 10];
    h_rel   = hd - H_LO;
    v_rel   = vd - V_LO;
    samp    = (hd >= H_LO) && (hd <= H_HI) && (vd >= V_LO) && (vd <= V_HI) &&
              (h_rel[1:0] == 2'b00) && (v_rel[1:0] == 2'b00);
    fs      = (hd == '0) && (vd == '0);
    wr_addr = 14'(v_rel[9:2]) * 14'(WIDTH) + 14'(h_rel[9:2]);
  end

  // Capture sequencing: arm on request, start at frame start, stop on last pixel.
  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    wr_en      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.capture_req) begin
          state_d    = S_ARMED;
          wr_count_d = '0;
        end
      end
      S_ARMED: begin
        if (fs) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // A frame start mid-capture means the previous frame was short: restart.
        if (fs) wr_count_d = '0;
        if (samp) begin
          wr_en      = 1'b1;
          wr_count_d = wr_count_d + 14'd1;
          if (wr_addr == LAST_ADDR) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read port: out-of-range addresses read as zero.
  always_comb begin
    rd_data_d = ({1'b0, bus.rd_addr} < DEPTH_W) ? mem[bus.rd_addr] : '0;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_count_q <= '0;
      rd_data_q  <= '0;
      pipe_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      rd_data_q  <= rd_data_d;
      pipe_q     <= pipe_d;
    end
  end

  // Frame RAM write port; contents survive reset, a reset cycle blocks the write.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_addr] <= bus.pix_in;
  end

  assign bus.busy     = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.wr_count = wr_count_q;
  assign bus.rd_data  = rd_data_q;

endmodule
